mem_lsu: RTL and testbench



---
 rtl/mem_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs one bus transaction per aligned load/store and
// holds the pipeline until the read data is captured.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        whilo_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] mem_addr_i,
    input  logic [5:0]  stall_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    output logic [3:0]  bus_sel_o,
    output logic        bus_we_o,
    output logic        bus_stb_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_data_i
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] rbuf_q;
    logic [31:0] bus_addr_q, bus_data_q;
    logic [3:0]  bus_sel_q;
    logic        bus_we_q, bus_stb_q;

    logic        is_mem, is_load, misaligned;
    logic [3:0]  sel_c;
    logic [31:0] sdata_c, load_c;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Only the MEM-stage bit of the stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^{stall_i[5], stall_i[3:0]};

    always_comb begin
        is_mem     = 1'b0;
        is_load    = 1'b0;
        misaligned = 1'b0;
        sel_c      = 4'b0000;
        sdata_c    = 32'h0;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
                sel_c   = 4'b1000 >> mem_addr_i[1:0];
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                is_mem     = 1'b1;
                is_load    = 1'b1;
                misaligned = mem_addr_i[0];
                sel_c      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            end
            EXE_LW_OP: begin
                is_mem     = 1'b1;
                is_load    = 1'b1;
                misaligned = |mem_addr_i[1:0];
                sel_c      = 4'b1111;
            end
            EXE_SB_OP: begin
                is_mem  = 1'b1;
                sel_c   = 4'b1000 >> mem_addr_i[1:0];
                sdata_c = {4{reg2_i[7:0]}};
            end
            EXE_SH_OP: begin
                is_mem     = 1'b1;
                misaligned = mem_addr_i[0];
                sel_c      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                sdata_c    = {2{reg2_i[15:0]}};
            end
            EXE_SW_OP: begin
                is_mem     = 1'b1;
                misaligned = |mem_addr_i[1:0];
                sel_c      = 4'b1111;
                sdata_c    = reg2_i;
            end
            default: ;
        endcase
    end

    // Big-endian lane extraction from the captured read word.
    always_comb begin
        case (mem_addr_i[1:0])
            2'b00:   byte_v = rbuf_q[31:24];
            2'b01:   byte_v = rbuf_q[23:16];
            2'b10:   byte_v = rbuf_q[15:8];
            default: byte_v = rbuf_q[7:0];
        endcase
        half_v = mem_addr_i[1] ? rbuf_q[15:0] : rbuf_q[31:16];
        case (aluop_i)
            EXE_LB_OP:  load_c = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: load_c = {24'h0, byte_v};
            EXE_LH_OP:  load_c = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: load_c = {16'h0, half_v};
            default:    load_c = rbuf_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rbuf_q     <= 32'h0;
            bus_addr_q <= 32'h0;
            bus_data_q <= 32'h0;
            bus_sel_q  <= 4'b0000;
            bus_we_q   <= 1'b0;
            bus_stb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (is_mem && !misaligned) begin
                        bus_addr_q <= {mem_addr_i[31:2], 2'b00};
                        bus_data_q <= sdata_c;
                        bus_sel_q  <= sel_c;
                        bus_we_q   <= !is_load;
                        bus_stb_q  <= 1'b1;
                    end
                end
                StBusy: begin
                    if (bus_stb_q && bus_ack_i) begin
                        rbuf_q    <= bus_data_i;
                        bus_stb_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        case (state_q)
            StIdle: begin
                if (is_mem) begin
                    wreg_o = 1'b0;
                    if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stallreq_o = 1'b1;
                        state_d    = StBusy;
                    end
                end
            end
            StBusy: begin
                stallreq_o = 1'b1;
                wreg_o     = 1'b0;
                if (bus_stb_q && bus_ack_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (is_load) begin
                    wdata_o = load_c;
                end else begin
                    wreg_o = 1'b0;
                end
                // Holding here while stalled elsewhere keeps the op from reissuing.
                if (!stall_i[4]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign wd_o       = wd_i;
    assign hi_o       = hi_i;
    assign lo_o       = lo_i;
    assign whilo_o    = whilo_i;
    assign bus_addr_o = bus_addr_q;
    assign bus_data_o = bus_data_q;
    assign bus_sel_o  = bus_sel_q;
    assign bus_we_o   = bus_we_q;
    assign bus_stb_o  = bus_stb_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu: a byte-lane reference model predicts bus lanes,
// store data, load results and the per-cycle stall/strobe sequence.
module tb_mem_lsu;

    localparam logic [7:0] LB  = 8'b1110_0000;
    localparam logic [7:0] LH  = 8'b1110_0001;
    localparam logic [7:0] LW  = 8'b1110_0011;
    localparam logic [7:0] LBU = 8'b1110_0100;
    localparam logic [7:0] LHU = 8'b1110_0101;
    localparam logic [7:0] SB  = 8'b1110_1000;
    localparam logic [7:0] SH  = 8'b1110_1001;
    localparam logic [7:0] SW  = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, hi_i, lo_i;
    logic        whilo_i;
    logic [7:0]  aluop_i;
    logic [31:0] reg2_i, mem_addr_i;
    logic [5:0]  stall_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o, stallreq_o, misalign_o;
    logic [31:0] bus_addr_o, bus_data_o;
    logic [3:0]  bus_sel_o;
    logic        bus_we_o, bus_stb_o, bus_ack_i;
    logic [31:0] bus_data_i;

    int n_tests = 0;
    int n_fail  = 0;

    mem_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .whilo_i    (whilo_i),
        .aluop_i    (aluop_i),
        .reg2_i     (reg2_i),
        .mem_addr_i (mem_addr_i),
        .stall_i    (stall_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .whilo_o    (whilo_o),
        .stallreq_o (stallreq_o),
        .misalign_o (misalign_o),
        .bus_addr_o (bus_addr_o),
        .bus_data_o (bus_data_o),
        .bus_sel_o  (bus_sel_o),
        .bus_we_o   (bus_we_o),
        .bus_stb_o  (bus_stb_o),
        .bus_ack_i  (bus_ack_i),
        .bus_data_i (bus_data_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 for non-memory ops.
    function automatic int op_size(input logic [7:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [7:0] op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

    function automatic bit op_signed(input logic [7:0] op);
        return (op == LB) || (op == LH);
    endfunction

    // Lane i of the bus carries byte address (3 - i); size bytes starting at off.
    function automatic logic [3:0] exp_sel(input int sz, input int off);
        int v;
        v = ((1 << sz) - 1) << (4 - sz - off);
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_store(input int sz, input logic [31:0] d);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input int sz, input int off, input bit sgn,
                                             input logic [31:0] word);
        logic [31:0] v, mask;
        v    = word >> (8 * (4 - sz - off));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        v    = v & mask;
        if (sgn && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic drive_fields();
        wd_i    = 5'($urandom);
        wreg_i  = 1'b1;
        wdata_i = $urandom;
        hi_i    = $urandom;
        lo_i    = $urandom;
        whilo_i = 1'($urandom);
    endtask

    task automatic alu_op(input bit spurious_ack);
        logic [7:0] op;
        @(posedge clk); #1;
        op = 8'($urandom);
        if (op_size(op) != 0) op = 8'h25;
        aluop_i    = op;
        mem_addr_i = $urandom;
        reg2_i     = $urandom;
        drive_fields();
        wreg_i     = 1'($urandom);
        bus_ack_i  = spurious_ack;
        bus_data_i = $urandom;
        @(negedge clk);
        check("alu_wd", 32'(wd_o), 32'(wd_i));
        check("alu_wreg", 32'(wreg_o), 32'(wreg_i));
        check("alu_wdata", wdata_o, wdata_i);
        check("alu_hi", hi_o, hi_i);
        check("alu_lo", lo_o, lo_i);
        check("alu_whilo", 32'(whilo_o), 32'(whilo_i));
        check("alu_stallreq", 32'(stallreq_o), 32'd0);
        check("alu_misalign", 32'(misalign_o), 32'd0);
        check("alu_stb", 32'(bus_stb_o), 32'd0);
        bus_ack_i = 1'b0;
    endtask

    task automatic mem_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdat,
                          input int waits, input logic [31:0] rword, input int hold);
        int sz, off;
        bit ld;
        sz  = op_size(op);
        off = int'(addr[1:0]);
        ld  = op_load(op);
        @(posedge clk); #1;
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = sdat;
        drive_fields();
        @(negedge clk);
        check("mem_wd", 32'(wd_o), 32'(wd_i));
        check("mem_whilo", 32'(whilo_o), 32'(whilo_i));
        check("mem_wreg_issue", 32'(wreg_o), 32'd0);
        check("mem_stb_issue", 32'(bus_stb_o), 32'd0);
        if (off % sz != 0) begin
            check("misalign_flag", 32'(misalign_o), 32'd1);
            check("misalign_stallreq", 32'(stallreq_o), 32'd0);
            return;
        end
        check("issue_misalign", 32'(misalign_o), 32'd0);
        check("issue_stallreq", 32'(stallreq_o), 32'd1);
        for (int c = 0; c <= waits; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("busy_stb", 32'(bus_stb_o), 32'd1);
            check("busy_stallreq", 32'(stallreq_o), 32'd1);
            check("busy_wreg", 32'(wreg_o), 32'd0);
            check("busy_whilo", 32'(whilo_o), 32'(whilo_i));
            check("busy_addr", bus_addr_o, {addr[31:2], 2'b00});
            check("busy_sel", 32'(bus_sel_o), 32'(exp_sel(sz, off)));
            check("busy_we", 32'(bus_we_o), 32'(!ld));
            if (!ld) check("busy_data", bus_data_o, exp_store(sz, sdat));
            if (c == waits) begin
                bus_ack_i  = 1'b1;
                bus_data_i = rword;
            end
        end
        @(posedge clk); #1;
        bus_ack_i  = 1'b0;
        bus_data_i = $urandom;
        stall_i    = (hold > 0) ? 6'h10 : 6'h00;
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            check("done_stallreq", 32'(stallreq_o), 32'd0);
            check("done_stb", 32'(bus_stb_o), 32'd0);
            check("done_wreg", 32'(wreg_o), 32'(ld));
            if (ld) check("done_wdata", wdata_o, exp_load(sz, off, op_signed(op), rword));
            if (h < hold) begin
                @(posedge clk); #1;
                if (h == hold - 1) stall_i = 6'h00;
            end
        end
    endtask

    initial begin
        logic [7:0] ops [8];
        ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW};
        rst = 1'b1;
        {wd_i, wreg_i, wdata_i, hi_i, lo_i, whilo_i, aluop_i, reg2_i, mem_addr_i} = '0;
        stall_i    = 6'h00;
        bus_ack_i  = 1'b0;
        bus_data_i = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stb", 32'(bus_stb_o), 32'd0);
        check("rst_we", 32'(bus_we_o), 32'd0);
        check("rst_sel", 32'(bus_sel_o), 32'd0);
        check("rst_addr", bus_addr_o, 32'd0);
        check("rst_data", bus_data_o, 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);
        check("rst_wd", 32'(wd_o), 32'd0);
        check("rst_wreg", 32'(wreg_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_whilo", 32'(whilo_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        mem_op(LW, 32'h100, 32'h0, 2, 32'hDEADBEEF, 0);
        mem_op(LB, 32'h103, 32'h0, 0, 32'h123456F0, 0);
        mem_op(LBU, 32'h103, 32'h0, 1, 32'h123456F0, 0);
        mem_op(SH, 32'h202, 32'h0000ABCD, 0, 32'h0, 0);
        mem_op(LW, 32'h101, 32'h0, 0, 32'h0, 0);
        alu_op(1'b0);
        mem_op(LH, 32'h402, 32'h0, 1, 32'h1234_8765, 3);
        alu_op(1'b1);

        // Reset while the bus cycle is outstanding, then a late ack.
        @(posedge clk); #1;
        aluop_i    = LW;
        mem_addr_i = 32'h300;
        drive_fields();
        @(negedge clk);
        check("rb_issue", 32'(stallreq_o), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rb_busy_stb", 32'(bus_stb_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        {wd_i, wreg_i, wdata_i, hi_i, lo_i, whilo_i, aluop_i, reg2_i, mem_addr_i} = '0;
        @(posedge clk); #1;
        rst        = 1'b0;
        bus_ack_i  = 1'b1;
        bus_data_i = 32'hCAFE_F00D;
        @(negedge clk);
        check("rb_stb", 32'(bus_stb_o), 32'd0);
        check("rb_stallreq", 32'(stallreq_o), 32'd0);
        check("rb_wdata", wdata_o, 32'd0);
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        @(negedge clk);
        check("rb_late_stb", 32'(bus_stb_o), 32'd0);
        check("rb_late_stallreq", 32'(stallreq_o), 32'd0);
        check("rb_late_sel", 32'(bus_sel_o), 32'd0);
        check("rb_late_wdata", wdata_o, 32'd0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                alu_op(1'($urandom));
            end else begin
                mem_op(ops[$urandom_range(0, 7)], $urandom, $urandom,
                       $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
            end
        end
        alu_op(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
